dmux8way_buffered: RTL
======================

// Module: dmux8way_buffered
// PURPOSE
//  Registered 8-way demultiplexer: the distribution-side counterpart of the 8-way word selector.
//  Accepts one word per cycle on a valid/ready input stream and steers it to one of eight
//    output channels chosen by a 3-bit select, or to all eight in broadcast mode.
//  Each output channel has a one-entry holding register with its own valid/ready handshake.
//  Sits between a single producer (CPU/ALU result bus) and eight downstream consumers.
// PARAMETERS
//  WIDTH   16   data word width in bits
// PORTS
//  clk        in   1         single clock; all state updates on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  in_data    in   WIDTH     input word
//  in_sel     in   3         target channel index 0..7 (ignored when in_bcast=1)
//  in_bcast   in   1         1 = deliver word to all eight channels
//  in_valid   in   1         input word present
//  in_ready   out  1         block can accept input this cycle
//  out_data   out  8*WIDTH   channel k data = out_data[k*WIDTH +: WIDTH]
//  out_valid  out  8         channel k holds a word
//  out_ready  in   8         consumer k takes word this cycle
//  busy       out  1         OR of out_valid
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_data=0, busy=0; any buffered words discarded.
//  Slot k "free" this cycle = ~out_valid[k] | out_ready[k] (empty, or draining now).
//  in_ready: in_bcast=0 -> free[in_sel]; in_bcast=1 -> AND of free[0..7].
//    Combinational from out_valid/out_ready/in_sel/in_bcast; no dependence on in_valid.
//  Accept = in_valid & in_ready. On accept, the target slot(s) load in_data and set
//    out_valid on the next edge. Latency input->output valid: exactly 1 cycle.
//  Drain: out_valid[k] & out_ready[k] clears slot k on the next edge unless it is reloaded
//    the same cycle (load wins; valid stays 1; new data) -> full throughput per channel.
//  Untargeted slots hold data and valid unchanged; out_data[k] holds its last value after drain.
//  Producer rule: once in_valid=1 it holds in_data/in_sel/in_bcast stable until accepted.
//  Broadcast is all-or-nothing: no partial delivery. A broadcast stalls until every slot is free.
//  No ordering between channels is guaranteed. Ordering within one channel is preserved.
//  out_ready[k] with out_valid[k]=0 has no effect.
//  busy = |out_valid (registered state only).
//  Slot FSM (per channel): EMPTY --load--> FULL; FULL --drain & ~load--> EMPTY;
//    FULL --drain & load--> FULL (new word); FULL --~drain--> FULL (hold).
//    A load into a FULL, non-draining slot is impossible because in_ready=0.
// STRUCTURE
//  Shared package/include: N_WAYS=8, SEL_W=3, default WORD_W=16.
//  Sub-module dmux_slot (one-entry register + valid FSM, ports clk, rst_n, load, d, ready,
//    valid, q, free); instantiated 8x via generate. Top holds the select decode, in_ready, busy.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with slots 2,5 full -> out_valid=0x00, busy=0
//    immediately; in_ready=1 after release.
//  2 Unicast: in_data=16'hA5A5, in_sel=3, valid 1 cycle, out_ready=0 -> next cycle
//    out_valid=0x08, ch3=A5A5; other channels unchanged.
//  3 Backpressure: ch6 full, out_ready[6]=0, in_sel=6 -> in_ready=0, slot kept;
//    raise out_ready[6] -> in_ready=1 same cycle, new word loaded next edge, valid[6] stays 1.
//  4 Throughput: 8 words to in_sel=1, out_ready[1]=1 -> one word/cycle out, in order, no gaps.
//  5 Broadcast: in_bcast=1, data 16'h1234, slot 4 full/stalled -> in_ready=0; release slot 4 ->
//    next edge out_valid=0xFF, all channels=1234.
//  6 Random: random sel/bcast/out_ready over 10k cycles vs. a per-channel FIFO model
//    -> no loss, no duplication, order preserved per channel.

Source files
------------

// File: rtl/dmux8way_buffered_pkg.sv
// Shared constants and types for the buffered 8-way demultiplexer.
package dmux8way_buffered_pkg;

    localparam int unsigned N_WAYS = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned WORD_W = 16;

    // Occupancy of a one-entry output slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : dmux8way_buffered_pkg

// File: rtl/dmux_slot.sv
// One-entry output holding register with a valid/ready handshake.
module dmux_slot
    import dmux8way_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic             free
);

    slot_state_t      state;
    slot_state_t      state_nxt;
    logic [WIDTH-1:0] q_nxt;

    // State and data registers; reset discards any buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
            q     <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
        end
    end

    // Next state: a load always wins over a same-cycle drain.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_nxt = SLOT_FULL;
                    q_nxt     = d;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    q_nxt = d;
                end else if (ready) begin
                    state_nxt = SLOT_EMPTY;
                end
            end
            default: state_nxt = SLOT_EMPTY;
        endcase
    end

    assign valid = (state == SLOT_FULL);
    // Free when empty or being drained this cycle.
    assign free  = ~valid | ready;

endmodule : dmux_slot

// File: rtl/dmux8way_buffered.sv
// Registered 8-way demultiplexer with per-channel one-entry buffers and broadcast.
module dmux8way_buffered
    import dmux8way_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_WAYS*WIDTH-1:0] out_data,
    output logic [N_WAYS-1:0]       out_valid,
    input  logic [N_WAYS-1:0]       out_ready,
    output logic                    busy
);

    logic [N_WAYS-1:0] free;
    logic [N_WAYS-1:0] load;
    logic              accept;
    logic              busy_nxt;

    // Select decode and input handshake; broadcast needs every slot free.
    always_comb begin
        in_ready = in_bcast ? (&free) : free[in_sel];
        accept   = in_valid & in_ready;
        load     = '0;
        for (int k = 0; k < int'(N_WAYS); k++) begin
            load[k] = accept & (in_bcast | (in_sel == SEL_W'(k)));
        end
        busy_nxt = |(load | (out_valid & ~out_ready));
    end

    // Busy tracks the OR of the slot valids as its own register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // One holding slot per output channel.
    for (genvar g = 0; g < int'(N_WAYS); g++) begin : g_slot
        dmux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[g]),
            .d     (in_data),
            .ready (out_ready[g]),
            .valid (out_valid[g]),
            .q     (out_data[g*WIDTH +: WIDTH]),
            .free  (free[g])
        );
    end

endmodule : dmux8way_buffered
